// File: rtl/column_scheduler_pkg.sv
// Shared definitions for the LED column scheduler.
//   state_e     : scheduler FSM states
//   NB_COLS_DEF : default number of multiplexed columns
package column_scheduler_pkg;

    localparam int NB_COLS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        DEAD,
        ON,
        WAIT_DRV
    } state_e;

endpackage

// File: rtl/column_scheduler_window.sv
// window_counter: loadable down-counter timing the DEAD and ON windows.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i this cycle (window length minus one)
//   load_val_i : value to load
//   done_o     : counter has reached zero (last cycle of the window)
module window_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/column_scheduler.sv
// column_scheduler: sequences the column multiplexer for one angular slice.
// On position_sync it requests columns one at a time from the driver
// controller and shows each with a dead time of all-off before it.
//   clk, rst       : clock, synchronous active-high reset
//   enable         : run enable; low blanks columns and returns to IDLE
//   position_sync  : start of a new slice (pulse)
//   driver_ready   : requested column is latched in the drivers (pulse)
//   overrun_clr    : clears the sticky overrun flag
//   col_start      : pulse, load column req_col into the drivers
//   req_col        : requested column index, valid with col_start
//   mux_out        : one-hot column enable, zero when blanked
//   col_idx        : column shown or next to be shown
//   slice_idx      : current slice index
//   slice_done     : pulse after the last column's ON window
//   overrun        : sticky, a sync arrived before the slice completed
module column_scheduler
    import column_scheduler_pkg::*;
#(
    parameter int NB_COLS     = NB_COLS_DEF,
    parameter int ON_CYCLES   = 2048,
    parameter int DEAD_CYCLES = 66,
    parameter int NB_SLICES   = 128,
    localparam int COL_W      = $clog2(NB_COLS),
    localparam int SLICE_W    = $clog2(NB_SLICES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               position_sync,
    input  logic               driver_ready,
    input  logic               overrun_clr,
    output logic               col_start,
    output logic [COL_W-1:0]   req_col,
    output logic [NB_COLS-1:0] mux_out,
    output logic [COL_W-1:0]   col_idx,
    output logic [SLICE_W-1:0] slice_idx,
    output logic               slice_done,
    output logic               overrun
);

    localparam int CNT_MAX = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [COL_W-1:0]     col_idx_q, col_idx_d;
    logic [COL_W-1:0]     req_col_q, req_col_d;
    logic [SLICE_W-1:0]   slice_idx_q, slice_idx_d, slice_next;
    logic [NB_COLS-1:0]   mux_out_q, mux_out_d;
    logic                 col_start_q, col_start_d;
    logic                 slice_done_q, slice_done_d;
    logic                 overrun_q, overrun_d;
    logic                 ready_q, ready_d;     // next column latched during current ON
    logic                 on_first_q, on_first_d;
    logic                 cnt_load, cnt_done;
    logic [CNT_W-1:0]     cnt_val;
    logic                 start_slice, abort, last_col;

    window_counter #(.CNT_W(CNT_W)) u_win (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    assign last_col   = (col_idx_q == COL_W'(NB_COLS - 1));
    assign slice_next = (slice_idx_q == SLICE_W'(NB_SLICES - 1)) ? '0 : slice_idx_q + SLICE_W'(1);

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        req_col_d    = req_col_q;
        slice_idx_d  = slice_idx_q;
        col_start_d  = 1'b0;
        slice_done_d = 1'b0;
        overrun_d    = overrun_q & ~overrun_clr;
        ready_d      = ready_q;
        cnt_load     = 1'b0;
        cnt_val      = DEAD_LD;
        start_slice  = 1'b0;
        abort        = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            col_idx_d = '0;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: start_slice = position_sync;
                PRELOAD: begin
                    if (position_sync) begin
                        abort = 1'b1;
                    end else if (driver_ready) begin
                        state_d  = DEAD;
                        cnt_load = 1'b1;
                    end
                end
                DEAD: begin
                    if (position_sync) begin
                        abort = 1'b1;
                    end else if (cnt_done) begin
                        state_d  = ON;
                        cnt_load = 1'b1;
                        cnt_val  = ON_LD;
                    end
                end
                ON: begin
                    if (cnt_done && last_col) begin
                        // a sync on this exact cycle is a clean restart, not an overrun
                        slice_done_d = 1'b1;
                        slice_idx_d  = slice_next;
                        col_idx_d    = '0;
                        state_d      = IDLE;
                        start_slice  = position_sync;
                    end else if (position_sync) begin
                        abort = 1'b1;
                    end else begin
                        // first ON cycle: issue the next request; a ready seen
                        // now predates that request and is dropped
                        if (on_first_q) begin
                            ready_d = 1'b0;
                            if (!last_col) begin
                                col_start_d = 1'b1;
                                req_col_d   = col_idx_q + COL_W'(1);
                            end
                        end else if (driver_ready) begin
                            ready_d = 1'b1;
                        end
                        if (cnt_done) begin
                            if (!on_first_q && (ready_q || driver_ready)) begin
                                col_idx_d = col_idx_q + COL_W'(1);
                                state_d   = DEAD;
                                cnt_load  = 1'b1;
                            end else begin
                                state_d = WAIT_DRV;
                            end
                        end
                    end
                end
                WAIT_DRV: begin
                    if (position_sync) begin
                        abort = 1'b1;
                    end else if (driver_ready) begin
                        col_idx_d = col_idx_q + COL_W'(1);
                        state_d   = DEAD;
                        cnt_load  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (abort) begin
            overrun_d   = 1'b1;
            slice_idx_d = slice_next;
            start_slice = 1'b1;
        end
        if (start_slice) begin
            state_d     = PRELOAD;
            col_start_d = 1'b1;
            req_col_d   = '0;
            col_idx_d   = '0;
            ready_d     = 1'b0;
        end

        // column enable follows the registered state, so it is one-hot only in ON
        mux_out_d  = (state_d == ON) ? (NB_COLS'(1) << col_idx_d) : '0;
        on_first_d = (state_d == ON) && (state_q != ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_idx_q    <= '0;
            req_col_q    <= '0;
            slice_idx_q  <= '0;
            mux_out_q    <= '0;
            col_start_q  <= 1'b0;
            slice_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            ready_q      <= 1'b0;
            on_first_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            req_col_q    <= req_col_d;
            slice_idx_q  <= slice_idx_d;
            mux_out_q    <= mux_out_d;
            col_start_q  <= col_start_d;
            slice_done_q <= slice_done_d;
            overrun_q    <= overrun_d;
            ready_q      <= ready_d;
            on_first_q   <= on_first_d;
        end
    end

    assign col_start  = col_start_q;
    assign req_col    = req_col_q;
    assign mux_out    = mux_out_q;
    assign col_idx    = col_idx_q;
    assign slice_idx  = slice_idx_q;
    assign slice_done = slice_done_q;
    assign overrun    = overrun_q;

endmodule
